imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the word-addressed instruction ROM (async read, 32-bit words, addr[9:2] index).
//  Owns the PC, drives the ROM address, and queues {pc, instr} pairs into a small FIFO for decode.
//  Decode drains the FIFO through a valid/ready handshake.
//  Supports branch/jump redirect with flush, and a halt/resume control.
//  Sits between the ROM and the decode stage of the RISC-V core.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] forced to 0
//  DEPTH      2              fetch FIFO entries (power of 2, >=2)
//  MEM_WORDS  256            ROM size in words; used only by bound check
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_addr       out  32  ROM byte address; = pc (combinational from pc reg)
//  imem_instr      in   32  ROM read data; valid in the same cycle as imem_addr
//  redirect_valid  in   1   redirect request; takes priority over all other events
//  redirect_pc     in   32  redirect target; bits [1:0] ignored (forced 0)
//  halt_req        in   1   stop fetching (level-sensitive)
//  out_valid       out  1   FIFO head is valid (count != 0)
//  out_instr       out  32  instruction at FIFO head
//  out_pc          out  32  PC of FIFO head
//  out_ready       in   1   decode accepts head; pop occurs when out_valid && out_ready
//  halted          out  1   state == HALTED
//  fault           out  1   state == FAULT (0 when IMEM_BOUND_CHECK_EN is not defined)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   pc=RESET_PC; FIFO empty; state=RUN; out_valid=0; out_instr=0; out_pc=0; halted=0; fault=0.
//  FSM states:
//   RUN:    fetch enabled.
//            halt_req=1 -> HALTED.
//            Bound violation -> FAULT (only when macro is defined).
//   HALTED: no push, pc held, FIFO keeps draining.
//            redirect_valid=1 -> RUN at redirect_pc. halt_req is ignored while HALTED.
//   FAULT:  no push, pc held. redirect_valid=1 -> RUN.
//  Push condition (RUN, no redirect, halt_req=0):
//   push = (count < DEPTH) || pop.
//   On push: FIFO <= {pc, imem_instr}; pc <= pc + 4.
//  Pop/push interaction:
//   Simultaneous pop+push with a full FIFO is legal; count is unchanged.
//  Latency:
//   First instruction is at the FIFO head with out_valid=1 one cycle after reset release.
//   Steady-state throughput is 1 instruction/cycle while out_ready=1.
//  Redirect (any state):
//   Flush FIFO (count=0; any pop that cycle is discarded); pc <= {redirect_pc[31:2], 2'b00}.
//   No push that cycle. out_valid=0 in the next cycle; target instr is valid the cycle after.
//  Halt: halt_req sampled in RUN blocks that cycle's push.
//  Wrap-around:
//   pc arithmetic is modulo 2^32.
//   ROM index wraps every MEM_WORDS words, since only addr[9:2] is decoded downstream.
//  Output stability:
//   While out_valid=1 && out_ready=0, out_instr and out_pc are held stable until the pop or a redirect.
//  Reset mid-operation: FIFO contents are discarded immediately; outputs return to reset values asynchronously.
// CONFIGURATION
//  IMEM_BOUND_CHECK_EN defined:
//   In RUN, if pc >= MEM_WORDS*4 there is no push and the next state is FAULT (fault=1).
//   Entries already in the FIFO still drain. Exit FAULT only via redirect to any pc.
//   Redirecting to an out-of-range pc re-faults on the following cycle.
//  IMEM_BOUND_CHECK_EN undefined:
//   No check; the fault port is tied to 0; addresses alias into the ROM.
// TESTING
//  1. ROM[0..3]=00100093,00200113,002081b3,00000013; reset; out_ready=1
//     -> pc/instr pairs 0/00100093, 4/00200113, 8/002081b3, C/00000013 on consecutive cycles.
//  2. out_ready=0 for 5 cycles after reset
//     -> count saturates at DEPTH, imem_addr holds 0x8, head stays pc=0.
//     Raise ready -> stream resumes with no loss or duplication.
//  3. redirect_valid=1, redirect_pc=0x0000_0013 while FIFO is full and a pop occurs
//     -> flush; next accepted out_pc=0x10; no stale entry ever shown.
//  4. halt_req=1 at pc=0x8 with 2 entries queued
//     -> halted=1, pc stays 0x8, 2 pops then out_valid=0.
//     Redirect to 0x4 -> RUN, out_pc=0x4 next.
//  5. Redirect to 0xFFFF_FFFC -> out_pc=FFFFFFFC then 0x0.
//     Macro defined: instead fault=1 and no push. Redirect to 0 clears the fault.
//  6. Assert rst_n=0 mid-stream (async, between edges)
//     -> out_valid=0 and imem_addr=RESET_PC immediately; restart as in scenario 1.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the async ROM and queues {pc, instr} pairs for decode.
// Optional ROM bound check enabled by defining IMEM_BOUND_CHECK_EN.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 2,
   parameter int          MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready,
   output logic        halted,
   output logic        fault,
   output logic [1:0]  state_dbg
);

   localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;
   localparam logic [AW:0] DEPTH_CNT   = DEPTH[AW:0];

   // Pointer wrap relies on DEPTH being a power of two.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MEM_WORDS < 1) begin : g_bad_cfg
      $error("imem_fetch_ctrl: DEPTH must be a power of 2 >= 2 and MEM_WORDS >= 1");
   end

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALTED = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   pc_mem_d [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   instr_mem_d [DEPTH];
   logic          halted_q, halted_d;
   logic          pop;
   logic          push;
   logic          bound_err;

`ifdef IMEM_BOUND_CHECK_EN
   localparam logic [31:0] PC_LIMIT = MEM_WORDS * 4;
   logic fault_q, fault_d;
   assign bound_err = (pc_q >= PC_LIMIT);
   assign fault     = fault_q;
`else
   assign bound_err = 1'b0;
   assign fault     = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      pop         = (count_q != '0) && out_ready;
      push        = 1'b0;

      if (redirect_valid) begin
         // Flush wins over everything, including a pop in the same cycle.
         state_d  = ST_RUN;
         pc_d     = redirect_pc & 32'hFFFF_FFFC;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (state_q == ST_RUN) begin
            if (halt_req) begin
               state_d = ST_HALTED;
            end else if (bound_err) begin
               state_d = ST_FAULT;
            end else begin
               push = (count_q < DEPTH_CNT) || pop;
            end
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push) begin
            pc_mem_d[wr_ptr_q]    = pc_q;
            instr_mem_d[wr_ptr_q] = imem_instr;
            wr_ptr_d              = wr_ptr_q + 1'b1;
            pc_d                  = pc_q + 32'd4;
         end
         count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   assign halted_d = (state_d == ST_HALTED);
`ifdef IMEM_BOUND_CHECK_EN
   assign fault_d  = (state_d == ST_FAULT);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC_AL;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
`ifdef IMEM_BOUND_CHECK_EN
         fault_q  <= 1'b0;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         halted_q    <= halted_d;
`ifdef IMEM_BOUND_CHECK_EN
         fault_q     <= fault_d;
`endif
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = (count_q != '0);
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign out_instr = instr_mem_q[rd_ptr_q];
   assign halted    = halted_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: ROM model, hand-computed vectors and an expected-PC queue.
module tb_imem_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic        halted;
   logic        fault;
   logic [1:0]  state_dbg;

   logic [31:0] rom [0:255];
   logic [31:0] exp_q [$];
   int          n_checks;
   int          n_pass;

   imem_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_ready      (out_ready),
      .halted         (halted),
      .fault          (fault),
      .state_dbg      (state_dbg)
   );

   assign imem_instr = rom[imem_addr[9:2]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic check_head(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check_eq({tag, "_qempty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
         check_eq({tag, "_pc"}, out_pc, e);
         check_eq({tag, "_instr"}, out_instr, rom[e[9:2]]);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks       = 0;
      n_pass         = 0;
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      halt_req       = 1'b0;
      out_ready      = 1'b0;
      for (int i = 4; i < 256; i++) rom[i] = 32'hC0DE_0000 | i;
      rom[0] = 32'h0010_0093;
      rom[1] = 32'h0020_0113;
      rom[2] = 32'h0020_81B3;
      rom[3] = 32'h0000_0013;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_pc", out_pc, 32'h0);
      check_eq("rst_instr", out_instr, 32'h0);
      check_eq("rst_addr", imem_addr, 32'h0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);
      check_eq("rst_fault", {31'd0, fault}, 32'd0);

      // 1: streaming with ready held high
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("s1_pc0", out_pc, 32'h0);
      check_eq("s1_in0", out_instr, 32'h0010_0093);
      check_eq("s1_v0", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      check_eq("s1_pc1", out_pc, 32'h4);
      check_eq("s1_in1", out_instr, 32'h0020_0113);
      @(negedge clk);
      check_eq("s1_pc2", out_pc, 32'h8);
      check_eq("s1_in2", out_instr, 32'h0020_81B3);
      @(negedge clk);
      check_eq("s1_pc3", out_pc, 32'hC);
      check_eq("s1_in3", out_instr, 32'h0000_0013);

      // 2: backpressure after reset, then resume
      out_ready = 1'b0;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check_eq("s2_hold_pc", out_pc, 32'h0);
         check_eq("s2_hold_instr", out_instr, 32'h0010_0093);
         check_eq("s2_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      check_eq("s2_addr", imem_addr, 32'h8);
      out_ready = 1'b1;
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      exp_q.push_back(32'h10);
      exp_q.push_back(32'h14);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_head("s2_stream");
      end

      // 3: redirect while full with a pop in the same cycle
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0013;
      @(negedge clk);
      redirect_valid = 1'b0;
      check_eq("s3_flush_valid", {31'd0, out_valid}, 32'd0);
      check_eq("s3_addr", imem_addr, 32'h10);
      exp_q.push_back(32'h10);
      exp_q.push_back(32'h14);
      @(negedge clk);
      check_head("s3_tgt");
      @(negedge clk);
      check_head("s3_next");

      // 4: halt with two entries queued
      out_ready = 1'b0;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      check_eq("s4_addr_pre", imem_addr, 32'h8);
      halt_req = 1'b1;
      @(negedge clk);
      check_eq("s4_halted", {31'd0, halted}, 32'd1);
      check_eq("s4_addr_hold", imem_addr, 32'h8);
      check_eq("s4_head0", out_pc, 32'h0);
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("s4_head1", out_pc, 32'h4);
      check_eq("s4_valid1", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      check_eq("s4_drained", {31'd0, out_valid}, 32'd0);
      check_eq("s4_addr_drn", imem_addr, 32'h8);
      @(negedge clk);
      check_eq("s4_still_empty", {31'd0, out_valid}, 32'd0);
      check_eq("s4_still_halted", {31'd0, halted}, 32'd1);
      halt_req       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h4;
      @(negedge clk);
      redirect_valid = 1'b0;
      check_eq("s4_resume_halted", {31'd0, halted}, 32'd0);
      check_eq("s4_resume_valid", {31'd0, out_valid}, 32'd0);
      check_eq("s4_resume_addr", imem_addr, 32'h4);
      @(negedge clk);
      check_eq("s4_resume_pc", out_pc, 32'h4);
      check_eq("s4_resume_instr", out_instr, 32'h0020_0113);

      // 5: redirect to the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      check_eq("s5_valid", {31'd0, out_valid}, 32'd0);
      check_eq("s5_addr", imem_addr, 32'hFFFF_FFFC);
`ifdef IMEM_BOUND_CHECK_EN
      @(negedge clk);
      check_eq("s5_fault", {31'd0, fault}, 32'd1);
      check_eq("s5_fault_valid", {31'd0, out_valid}, 32'd0);
      check_eq("s5_fault_addr", imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      check_eq("s5_fault_hold", {31'd0, fault}, 32'd1);
      check_eq("s5_nopush", {31'd0, out_valid}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      @(negedge clk);
      redirect_valid = 1'b0;
      check_eq("s5_fault_clr", {31'd0, fault}, 32'd0);
      @(negedge clk);
      check_eq("s5_after_pc", out_pc, 32'h0);
      check_eq("s5_after_instr", out_instr, 32'h0010_0093);
`else
      @(negedge clk);
      check_eq("s5_top_pc", out_pc, 32'hFFFF_FFFC);
      check_eq("s5_top_instr", out_instr, 32'hC0DE_00FF);
      @(negedge clk);
      check_eq("s5_wrap_pc", out_pc, 32'h0);
      check_eq("s5_wrap_instr", out_instr, 32'h0010_0093);
      check_eq("s5_nofault", {31'd0, fault}, 32'd0);
`endif

      // 6: asynchronous reset between edges
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("s6_valid", {31'd0, out_valid}, 32'd0);
      check_eq("s6_addr", imem_addr, 32'h0);
      check_eq("s6_pc", out_pc, 32'h0);
      check_eq("s6_halted", {31'd0, halted}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("s6_pc0", out_pc, 32'h0);
      check_eq("s6_in0", out_instr, 32'h0010_0093);
      @(negedge clk);
      check_eq("s6_pc1", out_pc, 32'h4);
      check_eq("s6_in1", out_instr, 32'h0020_0113);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
